// File: rtl/shift_divider_pkg.sv
// Shared types and default widths for the shift-and-subtract divider.
package shift_divider_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   localparam int DIV_M = 8;
   localparam int DIV_N = 8;
   localparam int DIV_CNT_W = $clog2(DIV_M + 1);

endpackage

// File: rtl/shift_subtract_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module shift_subtract_div_step #(
   parameter int n = 8
) (
   input  logic [n-1:0] w,
   input  logic         din,
   input  logic [n-1:0] b,
   output logic [n-1:0] w_nx,
   output logic         q_bit
);

   logic [n:0] shifted;

   // The n+1-bit shifted remainder is the working value; after restoring it always fits in n bits.
   assign shifted = {w, din};
   assign q_bit   = (shifted >= {1'b0, b});
   assign w_nx    = q_bit ? (shifted[n-1:0] - b) : shifted[n-1:0];

endmodule

// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIVIDER_DBZ_FAST_EN: a zero divisor finishes one clock after acceptance.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one restoring iteration per clock
module shift_and_subtract_binary_divider
   import shift_divider_pkg::*;
#(
   parameter int m = DIV_M,
   parameter int n = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [m-1:0] A,
   input  logic [n-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [m-1:0] Q,
   output logic [n-1:0] R,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(m + 1);

   state_t             state, state_nx;
   logic               load, iter, finish, last;
   logic [m-1:0]       dvd;
   logic [n-1:0]       w, w_nx, b_reg;
   logic               q_bit;
   logic [CNT_W-1:0]   cnt;
   logic               fast_dbz;
   logic [m-1:0]       q_fin;
   logic [n-1:0]       r_fin;

   shift_subtract_div_step #(.n(n)) u_step (
      .w     (w),
      .din   (dvd[m-1]),
      .b     (b_reg),
      .w_nx  (w_nx),
      .q_bit (q_bit)
   );

`ifdef DIVIDER_DBZ_FAST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       fast_dbz <= 1'b0;
      else if (load) fast_dbz <= (B == '0);
   end
`else
   assign fast_dbz = 1'b0;
`endif

   assign last = fast_dbz || (cnt == CNT_W'(m - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      iter     = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            iter = 1'b1;
            if (last) begin
               finish   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // The dividend register doubles as the quotient: bits leave at the MSB, quotient bits enter at the LSB.
   assign q_fin = fast_dbz ? '1 : {dvd[m-2:0], q_bit};
   assign r_fin = fast_dbz ? dvd[n-1:0] : w_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd         <= '0;
         w           <= '0;
         b_reg       <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            dvd   <= A;
            b_reg <= B;
            w     <= '0;
            cnt   <= '0;
         end else if (iter) begin
            dvd <= {dvd[m-2:0], q_bit};
            w   <= w_nx;
            cnt <= cnt + CNT_W'(1);
         end
         if (finish) begin
            Q           <= q_fin;
            R           <= r_fin;
            div_by_zero <= (b_reg == '0);
         end
      end
   end

   assign busy = (state == CALC);

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Scoreboard bench for shift_and_subtract_binary_divider (8/8 widths); honours DIVIDER_DBZ_FAST_EN.
module tb_shift_and_subtract_binary_divider;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [7:0] A, B;
   logic       busy, done, div_by_zero;
   logic [7:0] Q, R;

`ifdef DIVIDER_DBZ_FAST_EN
   localparam int DBZ_LAT = 1;
`else
   localparam int DBZ_LAT = 8;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   shift_and_subtract_binary_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 8'd0) begin
         e.q   = 8'hFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("q", 32'(Q), 32'(e.q));
            check("r", 32'(R), 32'(e.r));
            check("dbz", 32'(div_by_zero), 32'(e.dbz));
            if (e.b != 8'd0) begin
               check("inv_qb_plus_r", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
               check("r_lt_b", 32'(R < e.b), 32'd1);
            end
         end
      end
   end

   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int exp_lat);
      int lat;
      int nbusy;
      lat   = -1;
      nbusy = 0;
      push(a, b);
      @(posedge clk); #1;
      start = 1'b1; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; A = 8'($urandom); B = 8'($urandom);
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) begin
            lat = j;
            check("busy_at_done", 32'(busy), 32'd0);
            break;
         end
         if (busy) nbusy++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(nbusy), 32'(exp_lat));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int d1;
      int d2;
      rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q", 32'(Q), 32'd0);
      check("rst_r", 32'(R), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_div(8'd100, 8'd7, 8);
      run_div(8'd255, 8'd1, 8);
      run_div(8'd5, 8'd9, 8);
      run_div(8'd0, 8'd200, 8);
      run_div(8'hA5, 8'd0, DBZ_LAT);
      run_div(8'd37, 8'd37, 8);

      // start while busy is ignored; start held into the done cycle is accepted
      d1 = -1;
      d2 = -1;
      push(8'd100, 8'd7);
      @(posedge clk); #1;
      start = 1'b1; A = 8'd100; B = 8'd7;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 25; j++) begin
         if (j == 2) begin start = 1'b1; A = 8'd9; B = 8'd3; end
         if (j == 3) start = 1'b0;
         if (j == 7) begin start = 1'b1; A = 8'd9; B = 8'd3; push(8'd9, 8'd3); end
         if (j == 9) start = 1'b0;
         @(negedge clk);
         if (done) begin
            if (d1 < 0) d1 = j;
            else if (d2 < 0) d2 = j;
         end
         if (j == 8) check("b2b_busy_in_done_cycle", 32'(busy), 32'd0);
         if (j == 9) check("b2b_busy_rises", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      check("b2b_first_done", 32'(d1), 32'd8);
      check("b2b_second_done", 32'(d2), 32'd17);

      // reset mid-division: outputs clear at once and no done follows
      @(posedge clk); #1;
      start = 1'b1; A = 8'd200; B = 8'd13;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_q", 32'(Q), 32'd0);
      check("abort_r", 32'(R), 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      run_div(8'd200, 8'd13, 8);

      for (int i = 0; i < 1000; i++) begin
         run_div(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 8);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
